twiddle_seq_radix4: RTL and testbench
=====================================

Name: twiddle_seq_radix4

Overview:
Sequencer for the 16-point radix-4 FFT datapath. It walks both stages (4 butterflies x 4 legs each) and emits one 4-bit twiddle ROM address per accepted beat. The 4-bit twiddle ROM decodes the address to W_16^addr in Q15. The block sits between the FFT top-level control and the ROM/butterfly pipeline. It provides a valid/ready output handshake, an optional inter-stage drain gap, and inverse-FFT (conjugate twiddle) addressing.

Parameters:
GAP_CYCLES, 0, idle cycles inserted between the last beat of stage 0 and the first beat of stage 1 (range 0..15), used for butterfly pipeline drain.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a 16-point transform; sampled only in IDLE
inv  in  1  inverse mode; sampled together with an accepted start
out_ready  in  1  downstream ready for a twiddle beat
out_valid  out  1  tw_addr and the tags below are valid
tw_addr  out  4  twiddle ROM address (exponent k of W_16^k)
stage  out  1  current stage, 0 or 1
bfly  out  2  butterfly index within the stage, 0..3
leg  out  2  butterfly input index, 0..3
last_leg  out  1  high on leg 3 of each butterfly
last  out  1  high on the final beat (stage 1, bfly 3, leg 3)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0; latched inv 0.
- All outputs are registered; tw_addr is a pure function of the registered stage/bfly/leg/inv.
- States:
  - IDLE -> RUN on start. Latch inv. out_valid=1 on the next cycle with beat (0,0,0).
  - RUN: beat accepted when out_valid && out_ready. On accept, the leg increments; on leg wrap, bfly increments; on bfly wrap, stage increments.
  - RUN -> GAP: on acceptance of (stage0, bfly3, leg3) when GAP_CYCLES>0. With GAP_CYCLES=0, go straight to (1,0,0) with no bubble.
  - GAP: out_valid=0 for exactly GAP_CYCLES cycles, then RUN at (1,0,0).
  - RUN -> DONE on acceptance of the last beat.
  - DONE: done=1 and out_valid=0 for one cycle, then IDLE. busy drops in the same cycle that done rises.
- Handshake:
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - out_valid never drops without acceptance, except on reset.
  - Back-to-back acceptance gives one beat per cycle. Total: 32 beats for GAP_CYCLES=0; minimum start-to-done = 34 cycles.
- Address arithmetic:
  - Stage 0: e = (leg * bfly) mod 16, computed from a 4-bit product (max 9, no wrap needed).
  - Stage 1: e = 0.
  - tw_addr = inv ? ((16 - e) mod 16) : e, using 4-bit wrap, so e=0 gives 0.
- Start handling: start while busy or in DONE is ignored, and the latched inv is unchanged. start in the same cycle as DONE is ignored; it must be reasserted in IDLE.
- Reset mid-transform aborts immediately: outputs return to 0 with no done pulse.
- last_leg and last are valid only when out_valid=1, and are 0 otherwise.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0 for 10 cycles; start while rst=1 has no effect.
- Forward run, out_ready=1, GAP=0, inv=0 -> out_valid from cycle 1. Stage-0 addresses: bfly0 = 0,0,0,0; bfly1 = 0,1,2,3; bfly2 = 0,2,4,6; bfly3 = 0,3,6,9. Then 16 zeros. done pulses at cycle 33, busy low at cycle 33.
- Inverse run, inv=1 -> bfly3 addresses 0,13,10,7; bfly2 addresses 0,14,12,10; stage-1 addresses all 0.
- Backpressure: drop out_ready on beat (0,3,2) for 5 cycles -> tw_addr holds 6, tags hold (0,3,2), out_valid stays 1. On ready, the next beat is (0,3,3), addr 9.
- GAP_CYCLES=3 -> exactly 3 cycles with out_valid=0 between beat (0,3,3) and beat (1,0,0); done at cycle 36.
- Abort and retrigger: assert rst at beat 10 -> outputs 0 immediately, no done. start during RUN is ignored. A new start after reset gives a full 32-beat sequence.

Source files
------------

// File: rtl/twiddle_seq_radix4.sv
// Twiddle address sequencer for a 16-point radix-4 FFT: walks
// stage/butterfly/leg and emits one W_16^k ROM address per accepted beat.
module twiddle_seq_radix4 #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] tw_addr,
  output logic       stage,
  output logic [1:0] bfly,
  output logic [1:0] leg,
  output logic       last_leg,
  output logic       last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t     state, state_n;
  logic       inv_q, inv_n;
  logic [3:0] gap_cnt, gap_cnt_n;
  logic       valid_n, stage_n, last_leg_n, last_n, busy_n, done_n;
  logic [1:0] bfly_n, leg_n;
  logic       accept;
  logic [3:0] prod, e;

  assign accept = out_valid && out_ready;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inv_q     <= 1'b0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      stage     <= 1'b0;
      bfly      <= '0;
      leg       <= '0;
      last_leg  <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      inv_q     <= inv_n;
      gap_cnt   <= gap_cnt_n;
      out_valid <= valid_n;
      stage     <= stage_n;
      bfly      <= bfly_n;
      leg       <= leg_n;
      last_leg  <= last_leg_n;
      last      <= last_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state, counter advance and next-output computation
  always_comb begin
    state_n   = state;
    inv_n     = inv_q;
    gap_cnt_n = gap_cnt;
    valid_n   = out_valid;
    stage_n   = stage;
    bfly_n    = bfly;
    leg_n     = leg;
    busy_n    = busy;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          state_n = RUN;
          inv_n   = inv;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          stage_n = 1'b0;
          bfly_n  = '0;
          leg_n   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (stage && bfly == 2'd3 && leg == 2'd3) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            stage_n = 1'b0;
            bfly_n  = '0;
            leg_n   = '0;
          end else if (!stage && bfly == 2'd3 && leg == 2'd3) begin
            // Counters move to (1,0,0) now; the tags are parked there
            // with out_valid low while the drain gap runs.
            stage_n = 1'b1;
            bfly_n  = '0;
            leg_n   = '0;
            if (GAP_CYCLES > 0) begin
              state_n   = GAP;
              valid_n   = 1'b0;
              gap_cnt_n = 4'(GAP_CYCLES - 1);
            end
          end else begin
            leg_n = leg + 2'd1;
            if (leg == 2'd3) bfly_n = bfly + 2'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = RUN;
          valid_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    last_leg_n = valid_n && (leg_n == 2'd3);
    last_n     = valid_n && stage_n && (bfly_n == 2'd3) && (leg_n == 2'd3);
  end

  // Twiddle exponent from registered tags; conjugate by negation mod 16
  always_comb begin
    prod    = {2'b00, leg} * {2'b00, bfly};
    e       = stage ? 4'd0 : prod;
    tw_addr = inv_q ? (4'd0 - e) : e;
  end

endmodule

// File: tb/tb_twiddle_seq_radix4.sv
// Directed, table-driven bench for twiddle_seq_radix4 (GAP 0 and GAP 3 instances).
module tb_twiddle_seq_radix4;

  logic       clk = 1'b0;
  logic       rst, start, inv, out_ready;

  logic       out_valid, stage, last_leg, last, busy, done;
  logic [3:0] tw_addr;
  logic [1:0] bfly, leg;

  logic       g_valid, g_stage, g_last_leg, g_last, g_busy, g_done;
  logic [3:0] g_addr;
  logic [1:0] g_bfly, g_leg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       stg;
    logic [1:0] bf;
    logic [1:0] lg;
    logic [3:0] fa;
    logic [3:0] ia;
  } vec_t;

  vec_t       vec [32];
  logic [3:0] fwd0 [16];
  logic [3:0] inv0 [16];

  twiddle_seq_radix4 #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .out_ready(out_ready),
    .out_valid(out_valid), .tw_addr(tw_addr), .stage(stage), .bfly(bfly),
    .leg(leg), .last_leg(last_leg), .last(last), .busy(busy), .done(done)
  );

  twiddle_seq_radix4 #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .out_ready(out_ready),
    .out_valid(g_valid), .tw_addr(g_addr), .stage(g_stage), .bfly(g_bfly),
    .leg(g_leg), .last_leg(g_last_leg), .last(g_last), .busy(g_busy), .done(g_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_main"}, int'({out_valid, tw_addr, stage, bfly, leg, last_leg, last, busy, done}), 0);
    chk({name, "_gap"},  int'({g_valid, g_addr, g_stage, g_bfly, g_leg, g_last_leg, g_last, g_busy, g_done}), 0);
  endtask

  task automatic chk_beat(input int i, input logic iv);
    chk($sformatf("b%0d_valid", i), int'(out_valid), 1);
    chk($sformatf("b%0d_tags", i), int'({stage, bfly, leg}), int'({vec[i].stg, vec[i].bf, vec[i].lg}));
    chk($sformatf("b%0d_addr", i), int'(tw_addr), int'(iv ? vec[i].ia : vec[i].fa));
    chk($sformatf("b%0d_last_leg", i), int'(last_leg), int'(vec[i].lg == 2'd3));
    chk($sformatf("b%0d_last", i), int'(last), int'(i == 31));
    chk($sformatf("b%0d_busy_done", i), int'({busy, done}), 2);
  endtask

  // Full 32-beat run on the GAP=0 instance; optional 5-cycle stall at one beat.
  task automatic run_seq(input logic iv, input int stall_at);
    start = 1'b1; inv = iv; out_ready = 1'b1;
    step();
    start = 1'b0; inv = ~iv;
    for (int i = 0; i < 32; i++) begin
      chk_beat(i, iv);
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          chk_beat(i, iv);
        end
        out_ready = 1'b1;
      end
      step();
    end
    chk("done_pulse", int'({done, busy, out_valid}), 4);
    step();
    chk("done_clear", int'({done, busy, out_valid}), 0);
    inv = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    fwd0 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3,
             4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd3, 4'd6, 4'd9};
    inv0 = '{4'd0, 4'd0,  4'd0,  4'd0,  4'd0, 4'd15, 4'd14, 4'd13,
             4'd0, 4'd14, 4'd12, 4'd10, 4'd0, 4'd13, 4'd10, 4'd7};
    for (int i = 0; i < 32; i++) begin
      vec[i].stg = (i >= 16);
      vec[i].bf  = 2'((i / 4) % 4);
      vec[i].lg  = 2'(i % 4);
      vec[i].fa  = (i < 16) ? fwd0[i] : 4'd0;
      vec[i].ia  = (i < 16) ? inv0[i] : 4'd0;
    end

    // Reset with start held: must stay idle
    rst = 1'b1; start = 1'b1; inv = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    chk_idle("in_reset");
    rst = 1'b0; start = 1'b0; inv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_idle($sformatf("idle%0d", c));
    end

    run_seq(1'b0, -1);
    run_seq(1'b1, -1);
    run_seq(1'b0, 14);

    // Drain gap on the GAP=3 instance
    start = 1'b1; inv = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      chk($sformatf("gap_c%0d_valid", cyc), int'(g_valid),
          int'(cyc <= 16 || (cyc >= 20 && cyc <= 35)));
      chk($sformatf("gap_c%0d_done", cyc), int'(g_done), int'(cyc == 36));
      if (cyc == 16) chk("gap_pre_addr", int'({g_stage, g_bfly, g_leg, g_addr}), int'({5'b0_11_11, 4'd9}));
      if (cyc == 20) chk("gap_post_tags", int'({g_stage, g_bfly, g_leg, g_addr}), int'({5'b1_00_00, 4'd0}));
      if (cyc == 35) chk("gap_last", int'(g_last), 1);
      if (cyc == 36) chk("gap_busy", int'(g_busy), 0);
      step();
    end
    repeat (4) step();

    // Abort: ignored start mid-run, then reset at beat 10
    start = 1'b1; inv = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      chk_beat(i, 1'b0);
      if (i == 10) break;
      if (i == 5) begin start = 1'b1; inv = 1'b1; end
      step();
      start = 1'b0; inv = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_idle("abort_now");
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle($sformatf("abort%0d", c));
    end
    rst = 1'b0;
    step();
    chk_idle("abort_release");

    run_seq(1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
